udl_count_bank: RTL and testbench

Multi-channel, parametrised up/down/load counter bank for datapath and control sequencing. It holds CHANNELS independent WIDTH-bit counters, of which one is addressed per cycle. Each counter has a programmable step, a programmable upper limit, and a selectable saturate or wrap mode. Sticky overflow/underflow flags and one-cycle event pulses go to the controller.

---
 rtl/udl_count_bank.sv | 113 +++++++++++
 tb/tb_udl_count_bank.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/udl_count_bank.sv
// Bank of CHANNELS up/down/load counters sharing one step/limit/mode datapath;
// one channel is addressed per cycle, with sticky bound flags and an event pulse.
module udl_count_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned STEP_W   = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      up,
  input  logic                      down,
  input  logic                      load,
  input  logic [WIDTH-1:0]          din,
  input  logic [STEP_W-1:0]         step,
  input  logic [WIDTH-1:0]          limit,
  input  logic                      sat,
  input  logic                      clr_flags,
  output logic [CHANNELS*WIDTH-1:0] count_all,
  output logic [WIDTH-1:0]          count_sel,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       unf,
  output logic                      evt
);

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, unf_q;
  logic                evt_q;

  logic [WIDTH-1:0]    cur, nxt;
  logic                hit, act, set_ovf, set_unf;
  logic [WIDTH:0]      curw, stepw, limw, lim1, sum;
  logic [CHANNELS-1:0] sel_oh, ovf_set, unf_set;

  always_comb begin
    cur       = '0;
    hit       = 1'b0;
    sel_oh    = '0;
    count_all = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      count_all[i*WIDTH +: WIDTH] = cnt_q[i];
      if (sel == SEL_W'(i)) begin
        cur       = cnt_q[i];
        hit       = 1'b1;
        sel_oh[i] = 1'b1;
      end
    end
    count_sel = cur;

    curw    = {1'b0, cur};
    stepw   = (WIDTH+1)'(step);
    limw    = {1'b0, limit};
    lim1    = limw + (WIDTH+1)'(1);
    sum     = curw + stepw;
    nxt     = cur;
    set_ovf = 1'b0;
    set_unf = 1'b0;

    if (load) begin
      nxt = (din > limit) ? limit : din;
    end else if (up) begin
      if (step != '0) begin
        // A counter left above a lowered limit always takes the overflow path.
        if ((cur > limit) || (sum > limw)) begin
          set_ovf = 1'b1;
          if (sat)                              nxt = limit;
          else if ((cur > limit) || (stepw > lim1)) nxt = '0;
          else                                  nxt = WIDTH'(sum - lim1);
        end else begin
          nxt = WIDTH'(sum);
        end
      end
    end else if (down) begin
      if (step != '0) begin
        if (curw >= stepw) begin
          nxt = WIDTH'(curw - stepw);
        end else begin
          set_unf = 1'b1;
          if (sat)               nxt = '0;
          else if (stepw > lim1) nxt = limit;
          else                   nxt = WIDTH'(curw + lim1 - stepw);
        end
      end
    end

    act     = hit & (load | up | down);
    ovf_set = (hit && set_ovf) ? sel_oh : '0;
    unf_set = (hit && set_unf) ? sel_oh : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      ovf_q <= '0;
      unf_q <= '0;
      evt_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (act && sel_oh[i]) cnt_q[i] <= nxt;
      end
      // A flag set on the same edge as clr_flags survives.
      ovf_q <= (clr_flags ? '0 : ovf_q) | ovf_set;
      unf_q <= (clr_flags ? '0 : unf_q) | unf_set;
      evt_q <= (|ovf_set) | (|unf_set);
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
  assign evt = evt_q;

endmodule

// File: tb/tb_udl_count_bank.sv
// Directed bench for udl_count_bank: a 4-channel bank for the main sequences and a
// 3-channel bank for out-of-range select; expectations flow through a scoreboard queue.
module tb_udl_count_bank;

  logic        clk, rst, up, down, load, sat, clr_flags;
  logic [1:0]  sel;
  logic [7:0]  din, limit;
  logic [3:0]  step;
  logic [31:0] count_all;
  logic [7:0]  count_sel;
  logic [3:0]  ovf, unf;
  logic        evt;

  logic        up3, down3, load3;
  logic [1:0]  sel3;
  logic [23:0] count_all3;
  logic [7:0]  count_sel3;
  logic [2:0]  ovf3, unf3;
  logic        evt3;

  udl_count_bank #(.WIDTH(8), .CHANNELS(4), .STEP_W(4)) u_dut (
    .clk(clk), .rst(rst), .sel(sel), .up(up), .down(down), .load(load), .din(din),
    .step(step), .limit(limit), .sat(sat), .clr_flags(clr_flags), .count_all(count_all),
    .count_sel(count_sel), .ovf(ovf), .unf(unf), .evt(evt)
  );

  udl_count_bank #(.WIDTH(8), .CHANNELS(3), .STEP_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .sel(sel3), .up(up3), .down(down3), .load(load3), .din(din),
    .step(step), .limit(limit), .sat(sat), .clr_flags(clr_flags), .count_all(count_all3),
    .count_sel(count_sel3), .ovf(ovf3), .unf(unf3), .evt(evt3)
  );

  typedef struct {
    string       name;
    logic [31:0] all;
    logic [7:0]  csel;
    logic [3:0]  ovf, unf;
    logic        evt;
    logic [23:0] all3;
    logic [7:0]  csel3;
    logic [2:0]  ovf3, unf3;
    logic        evt3;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] e_cnt [4];
  logic [7:0] e_cnt3 [3];
  logic [3:0] e_ovf, e_unf;
  logic [2:0] e_ovf3, e_unf3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string what, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h want %h", nm, what, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "count_all", count_all, e.all);
        chk(e.name, "count_sel", {24'd0, count_sel}, {24'd0, e.csel});
        chk(e.name, "ovf", {28'd0, ovf}, {28'd0, e.ovf});
        chk(e.name, "unf", {28'd0, unf}, {28'd0, e.unf});
        chk(e.name, "evt", {31'd0, evt}, {31'd0, e.evt});
        chk(e.name, "count_all3", {8'd0, count_all3}, {8'd0, e.all3});
        chk(e.name, "count_sel3", {24'd0, count_sel3}, {24'd0, e.csel3});
        chk(e.name, "ovf3", {29'd0, ovf3}, {29'd0, e.ovf3});
        chk(e.name, "unf3", {29'd0, unf3}, {29'd0, e.unf3});
        chk(e.name, "evt3", {31'd0, evt3}, {31'd0, e.evt3});
      end
    end
  end

  // One command per clock. ev/eo/eu/ee are the hand-computed results for the
  // targeted bank (tgt 0 = 4-channel, tgt 1 = 3-channel); the other bank must hold.
  task automatic vec(input string nm, input bit rs, ld, u, d, clr, input int tgt,
                     input logic [1:0] s, input logic [7:0] di, input logic [3:0] st,
                     input logic [7:0] lim, input bit sa, input logic [7:0] ev,
                     input logic [3:0] eo, eu, input bit ee);
    exp_t e;
    @(negedge clk);
    rst = rs; clr_flags = clr; din = di; step = st; limit = lim; sat = sa;
    load  = (tgt == 0) ? ld : 1'b0;
    up    = (tgt == 0) ? u  : 1'b0;
    down  = (tgt == 0) ? d  : 1'b0;
    load3 = (tgt == 1) ? ld : 1'b0;
    up3   = (tgt == 1) ? u  : 1'b0;
    down3 = (tgt == 1) ? d  : 1'b0;
    if (tgt == 0) sel = s; else sel3 = s;
    e.name = nm;
    e.evt  = 1'b0;
    e.evt3 = 1'b0;
    if (rs) begin
      for (int i = 0; i < 4; i++) e_cnt[i] = 8'd0;
      for (int i = 0; i < 3; i++) e_cnt3[i] = 8'd0;
      e_ovf = '0; e_unf = '0; e_ovf3 = '0; e_unf3 = '0;
    end else if (tgt == 0) begin
      if (ld || u || d) e_cnt[s] = ev;
      e_ovf = eo; e_unf = eu; e.evt = ee;
      if (clr) begin e_ovf3 = '0; e_unf3 = '0; end
    end else begin
      if ((ld || u || d) && s < 2'd3) e_cnt3[s] = ev;
      e_ovf3 = eo[2:0]; e_unf3 = eu[2:0]; e.evt3 = ee;
      if (clr) begin e_ovf = '0; e_unf = '0; end
    end
    for (int i = 0; i < 4; i++) e.all[i*8 +: 8] = e_cnt[i];
    for (int i = 0; i < 3; i++) e.all3[i*8 +: 8] = e_cnt3[i];
    e.csel  = e_cnt[sel];
    e.csel3 = (sel3 < 2'd3) ? e_cnt3[sel3] : 8'd0;
    e.ovf = e_ovf; e.unf = e_unf; e.ovf3 = e_ovf3; e.unf3 = e_unf3;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; up = 0; down = 0; load = 0; clr_flags = 0; sat = 0;
    up3 = 0; down3 = 0; load3 = 0; sel = 0; sel3 = 0; din = 0; step = 0; limit = 8'd9;

    //  name              rs ld u d clr tgt sel din st lim sat  exp  ovf      unf      evt
    vec("reset",          1, 0, 0, 0, 0, 0, 0,   0, 0,  9, 0,   0, 4'b0000, 4'b0000, 0);
    vec("hold",           0, 0, 0, 0, 0, 0, 0,   0, 0,  9, 0,   0, 4'b0000, 4'b0000, 0);
    vec("ld_c2",          0, 1, 0, 0, 0, 0, 2,   5, 0,  9, 0,   5, 4'b0000, 4'b0000, 0);
    vec("rst_mid",        1, 0, 1, 0, 0, 0, 2,   0, 3,  9, 0,   0, 4'b0000, 4'b0000, 0);
    vec("ld_c1",          0, 1, 0, 0, 0, 0, 1,   8, 0,  9, 0,   8, 4'b0000, 4'b0000, 0);
    vec("up_wrap",        0, 0, 1, 0, 0, 0, 1,   0, 3,  9, 0,   1, 4'b0010, 4'b0000, 1);
    vec("dn_wrap",        0, 0, 0, 1, 0, 0, 1,   0, 3,  9, 0,   8, 4'b0010, 4'b0010, 1);
    vec("evt_drop",       0, 0, 0, 0, 0, 0, 1,   0, 3,  9, 0,   8, 4'b0010, 4'b0010, 0);
    vec("clr",            0, 0, 0, 0, 1, 0, 1,   0, 3,  9, 0,   8, 4'b0000, 4'b0000, 0);
    vec("up_sat",         0, 0, 1, 0, 0, 0, 1,   0, 3,  9, 1,   9, 4'b0010, 4'b0000, 1);
    vec("up_sat_again",   0, 0, 1, 0, 0, 0, 1,   0, 3,  9, 1,   9, 4'b0010, 4'b0000, 1);
    vec("ld_c1_2",        0, 1, 0, 0, 0, 0, 1,   2, 3,  9, 1,   2, 4'b0010, 4'b0000, 0);
    vec("dn_sat",         0, 0, 0, 1, 0, 0, 1,   0, 3,  9, 1,   0, 4'b0010, 4'b0010, 1);
    vec("clr2",           0, 0, 0, 0, 1, 0, 1,   0, 3,  9, 1,   0, 4'b0000, 4'b0000, 0);
    vec("ld_clamp",       0, 1, 0, 0, 0, 0, 0, 200, 0,100, 1, 100, 4'b0000, 4'b0000, 0);
    vec("updn_sat",       0, 0, 1, 1, 0, 0, 0,   0, 1,100, 1, 100, 4'b0001, 4'b0000, 1);
    vec("updn_wrap",      0, 0, 1, 1, 0, 0, 0,   0, 1,100, 0,   0, 4'b0001, 4'b0000, 1);
    vec("clr3",           0, 0, 0, 0, 1, 0, 0,   0, 0,100, 0,   0, 4'b0000, 4'b0000, 0);
    vec("set_vs_clr",     0, 0, 1, 0, 1, 0, 0,   0, 3,  2, 0,   0, 4'b0001, 4'b0000, 1);
    vec("clr4",           0, 0, 0, 0, 1, 0, 0,   0, 3,  2, 0,   0, 4'b0000, 4'b0000, 0);
    vec("ld_c2b",         0, 1, 0, 0, 0, 0, 2,   4, 0,  9, 0,   4, 4'b0000, 4'b0000, 0);
    vec("ld_c3",          0, 1, 0, 0, 0, 0, 3,   7, 0,  9, 0,   7, 4'b0000, 4'b0000, 0);
    vec("up_c3_to_lim",   0, 0, 1, 0, 0, 0, 3,   0, 2,  9, 0,   9, 4'b0000, 4'b0000, 0);
    vec("up_step0",       0, 0, 1, 0, 0, 0, 3,   0, 0,  9, 0,   9, 4'b0000, 4'b0000, 0);
    vec("dn_step0",       0, 0, 0, 1, 0, 0, 3,   0, 0,  9, 0,   9, 4'b0000, 4'b0000, 0);
    vec("up_lowlim_sat",  0, 0, 1, 0, 0, 0, 3,   0, 1,  5, 1,   5, 4'b1000, 4'b0000, 1);
    vec("ld_c3_9",        0, 1, 0, 0, 0, 0, 3,   9, 0,  9, 0,   9, 4'b1000, 4'b0000, 0);
    vec("up_lowlim_wrap", 0, 0, 1, 0, 0, 0, 3,   0, 1,  5, 0,   0, 4'b1000, 4'b0000, 1);
    vec("ld_c2_1",        0, 1, 0, 0, 0, 0, 2,   1, 0,  2, 0,   1, 4'b1000, 4'b0000, 0);
    vec("up_bigstep",     0, 0, 1, 0, 0, 0, 2,   0, 5,  2, 0,   0, 4'b1100, 4'b0000, 1);
    vec("dn_bigstep",     0, 0, 0, 1, 0, 0, 2,   0, 5,  2, 0,   2, 4'b1100, 4'b0100, 1);
    vec("dn_plain",       0, 0, 0, 1, 0, 0, 2,   0, 1,  9, 0,   1, 4'b1100, 4'b0100, 0);
    vec("b3_ld_c1",       0, 1, 0, 0, 0, 1, 1,   6, 0,  9, 0,   6, 4'b0000, 4'b0000, 0);
    vec("b3_up_oob",      0, 0, 1, 0, 0, 1, 3,   0, 1,  9, 0,   0, 4'b0000, 4'b0000, 0);
    vec("b3_ld_oob",      0, 1, 0, 0, 0, 1, 3,   5, 0,  9, 0,   0, 4'b0000, 4'b0000, 0);
    vec("b3_dn_oob",      0, 0, 0, 1, 0, 1, 3,   0, 1,  9, 1,   0, 4'b0000, 4'b0000, 0);
    vec("final_rst",      1, 0, 0, 0, 0, 0, 0,   0, 0,  9, 0,   0, 4'b0000, 4'b0000, 0);

    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("drain", "queue_left", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
